// File: rtl/alu_pipe_mc.sv
// Pipelined ALU/comparator with registered output, valid/ready handshakes and an iterative
// shift-add multiplier. Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow.
module alu_pipe_mc #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             oe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity,
  output logic             overflow,
  output logic             greater,
  output logic             is_eq,
  output logic             less,
  output logic             busy
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q;
  logic               out_valid_q, busy_q;
  logic [WIDTH-1:0]   y_q;
  logic               parity_q, overflow_q, greater_q, is_eq_q, less_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [ShW-1:0]     cnt_q;
  logic               mul_oe_q, mul_gt_q, mul_eq_q, mul_lt_q;

  logic               out_free, accept, is_sub, add_ovf, cmp_gt, cmp_eq, cmp_lt;
  logic [ShW-1:0]     sh;
  logic [WIDTH-1:0]   b_op, sum, res;
  logic               res_ovf;
  logic [2*WIDTH-1:0] shl_full;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == StIdle) && out_free;
  assign accept   = in_valid && in_ready;
  assign sh       = b[ShW-1:0];
  assign is_sub   = (op == 3'b001);

  assign cmp_gt = SIGNED_CMP ? ($signed(a) > $signed(b)) : (a > b);
  assign cmp_lt = SIGNED_CMP ? ($signed(a) < $signed(b)) : (a < b);
  assign cmp_eq = (a == b);

  always_comb begin
    b_op     = is_sub ? ~b : b;
    sum      = a + b_op + {{(WIDTH-1){1'b0}}, is_sub};
    add_ovf  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    shl_full = {{WIDTH{1'b0}}, a} << sh;
    res      = '0;
    res_ovf  = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        res     = sum;
        res_ovf = add_ovf;
`ifdef ALU_SAT_EN
        // Wrapped sign bit set means both operands were positive.
        if (add_ovf) res = sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: begin
        res     = shl_full[WIDTH-1:0];
        res_ovf = |shl_full[2*WIDTH-1:WIDTH];
      end
      3'b110: res = a >> sh;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      y_q         <= '0;
      parity_q    <= 1'b0;
      overflow_q  <= 1'b0;
      greater_q   <= 1'b0;
      is_eq_q     <= 1'b0;
      less_q      <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      mul_oe_q    <= 1'b0;
      mul_gt_q    <= 1'b0;
      mul_eq_q    <= 1'b0;
      mul_lt_q    <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept && op == 3'b111) begin
            state_q  <= StMul;
            busy_q   <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            mul_oe_q <= oe;
            mul_gt_q <= cmp_gt;
            mul_eq_q <= cmp_eq;
            mul_lt_q <= cmp_lt;
          end else if (accept) begin
            y_q         <= oe ? res : '0;
            parity_q    <= oe ? ^res : 1'b0;
            overflow_q  <= res_ovf;
            greater_q   <= cmp_gt;
            is_eq_q     <= cmp_eq;
            less_q      <= cmp_lt;
            out_valid_q <= 1'b1;
          end
        end
        StMul: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == ShW'(WIDTH - 1)) state_q <= StDone;
        end
        StDone: begin
          // Wait here until the output register can take the product.
          if (out_free) begin
            y_q         <= mul_oe_q ? acc_q[WIDTH-1:0] : '0;
            parity_q    <= mul_oe_q ? ^acc_q[WIDTH-1:0] : 1'b0;
            overflow_q  <= |acc_q[2*WIDTH-1:WIDTH];
            greater_q   <= mul_gt_q;
            is_eq_q     <= mul_eq_q;
            less_q      <= mul_lt_q;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;
  assign parity    = parity_q;
  assign overflow  = overflow_q;
  assign greater   = greater_q;
  assign is_eq     = is_eq_q;
  assign less      = less_q;

endmodule

// File: tb/tb_alu_pipe_mc.sv
// Directed bench for alu_pipe_mc: a signed-compare instance plus an unsigned-compare twin
// sharing the same stimulus.
module tb_alu_pipe_mc;

  logic       clk = 1'b0;
  logic       rst, in_valid, oe, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;

  logic       in_ready, out_valid, parity, overflow, greater, is_eq, less, busy;
  logic [7:0] y;
  logic       u_in_ready, u_out_valid, u_parity, u_overflow, u_greater, u_is_eq, u_less, u_busy;
  logic [7:0] u_y;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe_mc #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .oe(oe), .out_valid(out_valid), .out_ready(out_ready), .y(y), .parity(parity),
    .overflow(overflow), .greater(greater), .is_eq(is_eq), .less(less), .busy(busy)
  );

  alu_pipe_mc #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .a(a), .b(b), .op(op),
    .oe(oe), .out_valid(u_out_valid), .out_ready(out_ready), .y(u_y), .parity(u_parity),
    .overflow(u_overflow), .greater(u_greater), .is_eq(u_is_eq), .less(u_less), .busy(u_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic voe);
    op = o; a = va; b = vb; oe = voe; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int         lat;
    logic       seen;
    logic [7:0] hold_y;

    rst = 1'b1; in_valid = 1'b0; oe = 1'b1; out_ready = 1'b1; a = '0; b = '0; op = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_flags", {27'd0, parity, overflow, greater, is_eq, less}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD positive overflow
    issue(3'b000, 8'h7F, 8'h01, 1'b1);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
`ifdef ALU_SAT_EN
    chk("add_y", {24'd0, y}, 32'h7F);
`else
    chk("add_y", {24'd0, y}, 32'h80);
`endif
    chk("add_ovf", {31'd0, overflow}, 32'd1);
    chk("add_parity", {31'd0, parity}, 32'd1);
    chk("add_cmp", {29'd0, greater, is_eq, less}, 32'b100);

    // ADD negative overflow: -128 + -1
    issue(3'b000, 8'h80, 8'hFF, 1'b1);
`ifdef ALU_SAT_EN
    chk("addn_y", {24'd0, y}, 32'h80);
`else
    chk("addn_y", {24'd0, y}, 32'h7F);
`endif
    chk("addn_ovf", {31'd0, overflow}, 32'd1);

    issue(3'b001, 8'h05, 8'h05, 1'b1);
    chk("sub_eq_y", {24'd0, y}, 32'h00);
    chk("sub_eq_cmp", {29'd0, greater, is_eq, less}, 32'b010);
    chk("sub_eq_parity", {31'd0, parity}, 32'd0);
    chk("sub_eq_ovf", {31'd0, overflow}, 32'd0);

    issue(3'b001, 8'hFF, 8'h01, 1'b1);
    chk("sub_y", {24'd0, y}, 32'hFE);
    chk("sub_signed_cmp", {29'd0, greater, is_eq, less}, 32'b001);
    chk("sub_unsigned_cmp", {29'd0, u_greater, u_is_eq, u_less}, 32'b100);
    chk("sub_ovf", {31'd0, overflow}, 32'd0);

    // MUL 0x10 * 0x20 = 0x0200
    issue(3'b111, 8'h10, 8'h20, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mul_no_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    chk("mul_no_valid_c8", {31'd0, out_valid}, 32'd0);
    step();
    chk("mul_valid_c9", {31'd0, out_valid}, 32'd1);
    chk("mul_y", {24'd0, y}, 32'h00);
    chk("mul_ovf", {31'd0, overflow}, 32'd1);
    chk("mul_cmp", {29'd0, greater, is_eq, less}, 32'b001);
    chk("mul_busy_done", {31'd0, busy}, 32'd0);

    // MUL 0x0C * 0x0B = 0x84, accepted while the previous result is consumed
    issue(3'b111, 8'h0C, 8'h0B, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("mul2_latency", lat, 32'd9);
    chk("mul2_y", {24'd0, y}, 32'h84);
    chk("mul2_ovf", {31'd0, overflow}, 32'd0);
    chk("mul2_parity", {31'd0, parity}, 32'd0);
    chk("mul2_cmp", {29'd0, greater, is_eq, less}, 32'b100);

    // Backpressure with a new request waiting
    out_ready = 1'b0;
    op = 3'b000; a = 8'h03; b = 8'h04; oe = 1'b1; in_valid = 1'b1;
    #1;
    hold_y = y;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_y", {24'd0, y}, {24'd0, hold_y});
      chk("bp_ovf", {31'd0, overflow}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_new_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_new_y", {24'd0, y}, 32'h07);
    chk("bp_new_cmp", {29'd0, greater, is_eq, less}, 32'b001);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply
    issue(3'b111, 8'h03, 8'h05, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (12) begin
      step();
      seen = seen | out_valid;
    end
    chk("mrst_no_result", {31'd0, seen}, 32'd0);

    // XOR with output disabled
    issue(3'b100, 8'hA5, 8'hFF, 1'b0);
    chk("xor_y", {24'd0, y}, 32'h00);
    chk("xor_parity", {31'd0, parity}, 32'd0);
    chk("xor_u_cmp", {29'd0, u_greater, u_is_eq, u_less}, 32'b001);
    chk("xor_s_cmp", {29'd0, greater, is_eq, less}, 32'b001);

    issue(3'b101, 8'h81, 8'h01, 1'b1);
    chk("shl_y", {24'd0, y}, 32'h02);
    chk("shl_ovf", {31'd0, overflow}, 32'd1);
    chk("shl_parity", {31'd0, parity}, 32'd1);

    // Upper bits of b ignored as shift amount
    issue(3'b101, 8'h01, 8'h09, 1'b1);
    chk("shl_amt_y", {24'd0, y}, 32'h02);
    chk("shl_amt_ovf", {31'd0, overflow}, 32'd0);

    issue(3'b110, 8'h80, 8'h07, 1'b1);
    chk("shr_y", {24'd0, y}, 32'h01);
    chk("shr_ovf", {31'd0, overflow}, 32'd0);

    issue(3'b010, 8'hF0, 8'h3C, 1'b1);
    chk("and_y", {24'd0, y}, 32'h30);
    issue(3'b011, 8'hF0, 8'h0C, 1'b1);
    chk("or_y", {24'd0, y}, 32'hFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
